// File: rtl/sink_checker_if.sv
// Flit handshake bundle between a NoC egress port and a sink.
// Carries data, valid and the sink's ready.
interface sink_checker_if #(
  parameter int WIDTH = 32
) ();
  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic             ready_out;

  modport master (
    output data_in,
    output valid_in,
    input  ready_out
  );

  modport slave (
    input  data_in,
    input  valid_in,
    output ready_out
  );
endinterface

// File: rtl/sink_checker.sv
// NoC traffic sink: backpressure generator, header checker, stats.
// Define SINK_TRACE_EN for a simulation-only transfer/error trace.
module sink_checker #(
  parameter int WIDTH        = 32,
  parameter int N            = 16,
  parameter int N_ADDR_WIDTH = $clog2(N),
  parameter int NODE         = 15,
  parameter int ID_WIDTH     = 8,
  parameter int CNT_WIDTH    = 32,
  parameter int BP_MODE      = 0,
  parameter int BP_PERIOD    = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst,
  sink_checker_if.slave           bus,
  output logic [CNT_WIDTH-1:0]    rx_count,
  output logic [CNT_WIDTH-1:0]    err_dst_count,
  output logic [CNT_WIDTH-1:0]    err_seq_count,
  output logic                    err_flag,
  output logic [N_ADDR_WIDTH-1:0] last_err_src
);

  localparam int AW  = N_ADDR_WIDTH;
  localparam int IW  = ID_WIDTH;
  localparam int PW  = WIDTH - 2 * AW - IW;
  localparam int PHW = $clog2(BP_PERIOD);

  localparam logic [PHW-1:0] PH_LAST =
    PHW'(BP_PERIOD - 1);
  localparam logic [AW-1:0] NODE_ID = AW'(NODE);
  localparam logic [AW:0] N_EXT = (AW + 1)'(N);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  // Header fields
  logic [AW-1:0] src;
  logic [AW-1:0] dst;
  logic [IW-1:0] id;
  logic [PW-1:0] payload;

  assign src     = bus.data_in[WIDTH-1 -: AW];
  assign dst     = bus.data_in[WIDTH-1-AW -: AW];
  assign id      = bus.data_in[WIDTH-1-2*AW -: IW];
  assign payload = bus.data_in[PW-1:0];

  logic unused_payload;
  assign unused_payload = ^payload;

  // Backpressure state
  logic [PHW-1:0] phase_q, phase_d;
  logic [15:0]    lfsr_q, lfsr_d;
  logic           lfsr_fb;
  logic           ready_q, ready_d;

  always_comb begin
    phase_d = phase_q + 1'b1;
    if (phase_q == PH_LAST) begin
      phase_d = '0;
    end
  end

  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13]
                 ^ lfsr_q[12] ^ lfsr_q[10];
  assign lfsr_d  = {lfsr_q[14:0], lfsr_fb};

  always_comb begin
    ready_d = 1'b1;
    unique case (1'b1)
      (BP_MODE == 1): ready_d = (phase_d != PH_LAST);
      (BP_MODE == 2): ready_d = lfsr_d[0];
      default:        ready_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= '0;
      lfsr_q  <= LFSR_SEED;
      ready_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      lfsr_q  <= lfsr_d;
      ready_q <= ready_d;
    end
  end

  assign bus.ready_out = ready_q;

  // Header check
  logic          xfer;
  logic          src_oob;
  logic [IW-1:0] exp_q [N];
  logic [IW-1:0] exp_rd;
  logic          dst_err;
  logic          seq_err;
  logic          any_err;

  assign xfer    = bus.valid_in & ready_q;
  assign src_oob = ({1'b0, src} >= N_EXT);
  assign exp_rd  = src_oob ? '0 : exp_q[src];
  assign dst_err = (dst != NODE_ID);
  assign seq_err = src_oob | (id != exp_rd);
  assign any_err = dst_err | seq_err;

  // Table writes land on the edge, so the next flit reads them directly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        exp_q[i] <= '0;
      end
    end else if (xfer && !src_oob) begin
      exp_q[src] <= id + 1'b1;
    end
  end

  // Statistics
  logic [CNT_WIDTH-1:0] rx_q, rx_d;
  logic [CNT_WIDTH-1:0] edst_q, edst_d;
  logic [CNT_WIDTH-1:0] eseq_q, eseq_d;
  logic                 flag_q, flag_d;
  logic [AW-1:0]        lsrc_q, lsrc_d;

  always_comb begin
    rx_d   = rx_q;
    edst_d = edst_q;
    eseq_d = eseq_q;
    flag_d = flag_q;
    lsrc_d = lsrc_q;
    if (xfer) begin
      if (rx_q != CNT_MAX) begin
        rx_d = rx_q + 1'b1;
      end
      if (dst_err && edst_q != CNT_MAX) begin
        edst_d = edst_q + 1'b1;
      end
      if (seq_err && eseq_q != CNT_MAX) begin
        eseq_d = eseq_q + 1'b1;
      end
      if (any_err) begin
        flag_d = 1'b1;
        lsrc_d = src;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_q   <= '0;
      edst_q <= '0;
      eseq_q <= '0;
      flag_q <= 1'b0;
      lsrc_q <= '0;
    end else begin
      rx_q   <= rx_d;
      edst_q <= edst_d;
      eseq_q <= eseq_d;
      flag_q <= flag_d;
      lsrc_q <= lsrc_d;
    end
  end

  assign rx_count      = rx_q;
  assign err_dst_count = edst_q;
  assign err_seq_count = eseq_q;
  assign err_flag      = flag_q;
  assign last_err_src  = lsrc_q;

`ifdef SINK_TRACE_EN
  always @(posedge clk) begin
    if (!rst && xfer) begin
      $display(
        "RECV; time=%0t; from=%0d; to=%0d; curr=%0d; id=%0d; data=%0h;",
        $time, src, dst, NODE, id, bus.data_in);
      if (dst_err) begin
        $display("ERR; type=DST; expected_id=%0d", exp_rd);
      end
      if (seq_err) begin
        $display("ERR; type=SEQ; expected_id=%0d", exp_rd);
      end
    end
  end
`endif

endmodule
